i2s_master_ctrl: RTL

I2S_MASTER_CTRL -- requirements
Module: i2s_master_ctrl

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_sck_div.sv | 44 ++++
 rtl/i2s_master_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared types and default sizing for the I2S master controller.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_CLK_DIV    = 4;

endpackage

// File: rtl/i2s_sck_div.sv
// Serial-clock divider: toggles o_sck every CLK_DIV enabled cycles and flags
// the cycle before each rising/falling toggle.
module i2s_sck_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_sys_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_sck,
  output logic o_fall_tick,
  output logic o_rise_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_div;
  logic          r_sck;
  logic          w_term;

  assign w_term = i_en && !i_clr && (r_div == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (i_clr) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (i_en) begin
      if (w_term) begin
        r_div <= '0;
        r_sck <= ~r_sck;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_sck       = r_sck;
  assign o_fall_tick = w_term && r_sck;
  assign o_rise_tick = w_term && !r_sck;

endmodule

// File: rtl/i2s_master_ctrl.sv
// I2S master frame controller: generates SCK/WS and counts frames.
// Optional completion interrupt enabled by defining I2S_FRAME_IRQ_EN.
module i2s_master_ctrl
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV
) (
  input  logic        i_clk,
  input  logic        i_sys_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [15:0] i_num_frames,
  output logic        o_sck,
  output logic        o_ws,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt
`ifdef I2S_FRAME_IRQ_EN
  ,
  input  logic        i_irq_clr,
  output logic        o_irq
`endif
);

  localparam int unsigned BW = $clog2(2 * DATA_WIDTH);
  localparam logic [BW-1:0] BIT_LAST     = BW'(2 * DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_LEFT_END = BW'(DATA_WIDTH - 1);

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_bit, w_bit_nxt;
  logic          r_ws, r_frame_done;
  logic [15:0]   r_frame_cnt, r_num_frames;
  logic          w_fall, w_wrap, w_last_frame, w_idle;

  assign w_idle = (r_state == ST_IDLE);

  i2s_sck_div #(.CLK_DIV(CLK_DIV)) u_sck_div (
    .i_clk       (i_clk),
    .i_sys_rst   (i_sys_rst),
    .i_en        (!w_idle),
    .i_clr       (w_idle),
    .o_sck       (o_sck),
    .o_fall_tick (w_fall),
    .o_rise_tick ()
  );

  assign w_bit_nxt    = (r_bit == BIT_LAST) ? '0 : r_bit + 1'b1;
  assign w_wrap       = w_fall && (r_bit == BIT_LAST);
  assign w_last_frame = (r_num_frames != '0) && ((r_frame_cnt + 16'd1) == r_num_frames);

  always_ff @(posedge i_clk or posedge i_sys_rst) begin
    if (i_sys_rst) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // A stop arriving on the wrap cycle ends the run there rather than via DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start && !i_stop) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_wrap && (i_stop || w_last_frame)) w_state_nxt = ST_IDLE;
        else if (i_stop)                        w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (w_wrap) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_bit        <= '0;
      r_ws         <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_num_frames <= '0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_idle) begin
        r_bit <= '0;
        r_ws  <= 1'b0;
        if (w_state_nxt == ST_RUN) begin
          r_frame_cnt  <= '0;
          r_num_frames <= i_num_frames;
        end
      end else if (w_fall) begin
        r_bit <= w_bit_nxt;
        if (w_bit_nxt == BIT_LEFT_END) r_ws <= 1'b1;
        else if (w_bit_nxt == BIT_LAST) r_ws <= 1'b0;
        if (w_wrap) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign o_ws         = r_ws;
  assign o_busy       = !w_idle;
  assign o_frame_done = r_frame_done;
  assign o_frame_cnt  = r_frame_cnt;

`ifdef I2S_FRAME_IRQ_EN
  logic r_irq;

  always_ff @(posedge i_clk or posedge i_sys_rst) begin
    if (i_sys_rst)                             r_irq <= 1'b0;
    else if (!w_idle && w_state_nxt == ST_IDLE) r_irq <= 1'b1;
    else if (i_irq_clr)                        r_irq <= 1'b0;
  end

  assign o_irq = r_irq;
`endif

endmodule
